// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// DEPTH-entry FIFO of {pc, inst} pairs feeding the IF/ID register.
// When full, a push is accepted only together with a pop.
module fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic [XLEN-1:0]         push_inst,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid && !clear;
  assign do_push    = push && !clear && ((count != FULL_COUNT) || do_pop);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_inst  = inst_mem[rd_ptr];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch FSM, fetch PC and imem handshake; instructions queue in fetch_buffer
// and the head is presented to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = if_fetch_unit_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_EN_IF,
  input  logic        redirect_IF,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_IF,
  output logic [31:0] PC_IF,
  output logic        valid_IF
);

  import if_fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  fetch_state_t state, next_state;
  logic [31:0]  fetch_pc, next_pc, pc_plus4, last_pc;
  logic [31:0]  head_pc, head_inst;
  logic [CW-1:0] count;
  logic [CW:0]  occupancy;
  logic         head_valid, room, req, push, pop, clear;

  assign pc_plus4  = fetch_pc + 32'd4;
  // An outstanding fetch reserves a slot; same-cycle pops are not credited.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, (state == S_WAIT)};
  assign room      = occupancy < DEPTH_W;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    req        = 1'b0;
    imem_addr  = fetch_pc;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    if (redirect_IF) begin
      clear   = 1'b1;
      next_pc = redirect_pc & ~32'd3;
      case (state)
        S_WAIT, S_KILL: next_state = imem_rvalid ? S_IDLE : S_KILL;
        default:        next_state = S_IDLE;
      endcase
    end else begin
      pop = PC_EN_IF && head_valid;
      case (state)
        S_IDLE: begin
          if (room) begin
            req        = 1'b1;
            next_state = imem_ready ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          req = 1'b1;
          if (imem_ready) next_state = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            push      = 1'b1;
            next_pc   = pc_plus4;
            imem_addr = pc_plus4;
            if (room) begin
              req        = 1'b1;
              next_state = imem_ready ? S_WAIT : S_REQ;
            end else begin
              next_state = S_IDLE;
            end
          end
        end
        S_KILL: begin
          if (imem_rvalid) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  assign imem_req = req && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      last_pc  <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
      if (pop) last_pc <= head_pc;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_inst  (imem_rdata),
    .pop        (pop),
    .count      (count),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst)
  );

  assign valid_IF = head_valid;
  assign PC_IF    = head_valid ? head_pc : last_pc;
  assign inst_IF  = head_valid ? head_inst : NOP_INST;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end. It sits between the PC and the IF/ID pipeline register. It owns the fetch PC and issues requests to the instruction memory over a ready/valid handshake. Returned instructions go into a small buffer, and the unit presents {PC, instruction, valid} to the IF/ID register. It obeys the hazard unit's PC_EN_IF stall and reg_FD_flush redirect, and drops any in-flight fetch that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset
DEPTH, 2, instruction buffer entries; power of two, at least 2
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid entry

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
PC_EN_IF  input  1  1 = ID may consume the head entry this cycle; 0 = hold the head entry
redirect_IF  input  1  branch/jump taken (same timing as reg_FD_flush)
redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 00
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  memory accepts the request when imem_req & imem_ready
imem_rvalid  input  1  response valid; at most one response per accepted request, earliest 1 cycle after acceptance
imem_rdata  input  32  response instruction
inst_IF  output  32  head instruction, or NOP_INST when valid_IF=0
PC_IF  output  32  PC of the head instruction (last consumed PC when valid_IF=0)
valid_IF  output  1  head entry valid

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; buffer empty; state IDLE.
  - imem_req=0, valid_IF=0, inst_IF=NOP_INST, PC_IF=RESET_PC.
  - Reset applied mid-transaction abandons the transaction; the memory side is also reset.
- States: IDLE (nothing outstanding), REQ (imem_req held, not yet accepted), WAIT (accepted, awaiting rvalid), KILL (accepted, response to be discarded).
- At most one outstanding request.
- Room condition: room = (count + (state==WAIT)) < DEPTH. Pops in the current cycle are not credited.
- IDLE:
  - If room and no redirect: drive imem_req=1, imem_addr=fetch_pc.
  - If ready: go to WAIT; otherwise go to REQ.
- REQ:
  - imem_req and imem_addr are held stable until accepted.
  - On acceptance: go to WAIT.
  - On redirect before acceptance: deassert req, go to IDLE. No memory side effect.
- WAIT:
  - On rvalid: push {fetch_pc, rdata}, then fetch_pc += 4.
  - In the same cycle a new request may issue at fetch_pc+4 if room is still true; go to REQ/WAIT accordingly, otherwise IDLE.
- KILL: on rvalid, discard the data and go to IDLE. A redirect while in KILL stays in KILL.
- Redirect (redirect_IF=1) has priority over everything:
  - Buffer cleared; fetch_pc=redirect_pc&~3; imem_req=0 that cycle.
  - WAIT goes to KILL, unless rvalid is also high that cycle, in which case the data is discarded and the state goes to IDLE.
  - No pop occurs that cycle. The first request to the target issues the next cycle.
- Pop: when PC_EN_IF=1, valid_IF=1 and redirect_IF=0, the head is consumed. Simultaneous push and pop when full is legal.
- Output timing:
  - Outputs come registered from the buffer head; there is no rdata bypass.
  - Minimum latency: request accepted at cycle t, rvalid at t+1, valid_IF at t+2.
- Empty buffer with PC_EN_IF=1: valid_IF=0 and inst_IF=NOP_INST, so the downstream stage sees a bubble.
- PC wrap: 32'hFFFF_FFFC + 4 wraps to 0; no exception is raised.
- Ignored inputs: rvalid in IDLE or REQ is ignored and does not change state.

Decomposition:
- Shared package: fetch state enum (IDLE/REQ/WAIT/KILL), NOP_INST constant, XLEN=32.
- One sub-module: fetch_buffer, a DEPTH-entry FIFO of {pc, inst} with sync clear, push, pop, count, head outputs; simultaneous push+pop allowed when full.
- Everything else (FSM, fetch_pc, handshake) lives in if_fetch_unit.

Test Plan:
- Reset, then imem_ready=1 with 1-cycle rvalid latency and PC_EN_IF=1 → requests to 0x0, 0x4, 0x8; valid_IF first high 2 cycles after the first acceptance, with PC_IF 0x0, 0x4, 0x8 consecutively.
- Hold PC_EN_IF=0 for 5 cycles → buffer fills to 2, imem_req drops, PC_IF/inst_IF stay at 0x0. On release, no entry is lost or duplicated.
- Request to 0x8 accepted, then redirect_IF=1 with redirect_pc=0x103 the next cycle, and rvalid arrives 2 cycles later → that response is discarded; next request addr=0x100; first valid PC_IF=0x100.
- Redirect while in REQ with imem_ready=0 → imem_req deasserts the same cycle; next request addr=redirect target.
- Redirect in the same cycle as rvalid in WAIT → data dropped, state IDLE, buffer empty, valid_IF=0 the next cycle.
- rst=1 asserted while in WAIT with a full buffer → next cycle valid_IF=0, imem_req=0, PC_IF=RESET_PC; first post-reset request addr=RESET_PC.
